// File: rtl/fifo_arb_pkg.sv
// Shared types and width helper for the FIFO read arbiter.
package fifo_arb_pkg;

  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} arb_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_rd_arb_if.sv
// FIFO-bank read side plus the registered output stream of the arbiter.
interface fifo_rd_arb_if #(
  parameter int NCH   = 4,
  parameter int DSIZE = 8
);
  localparam int CW = fifo_arb_pkg::clog2(NCH);

  logic [NCH-1:0]       rempty;
  logic [NCH*DSIZE-1:0] rdata;
  logic [NCH-1:0]       rinc;
  logic [NCH-1:0]       ch_en;
  logic [DSIZE-1:0]     out_data;
  logic [CW-1:0]        out_ch;
  logic                 out_valid;
  logic                 out_ready;
  logic                 busy;

  modport master (
    input  rempty, rdata, ch_en, out_ready,
    output rinc, out_data, out_ch, out_valid, busy
  );

  modport slave (
    output rempty, rdata, ch_en, out_ready,
    input  rinc, out_data, out_ch, out_valid, busy
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit after 'last', wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  last,
  output logic [CW-1:0]  gnt_idx,
  output logic           gnt_any
);

  int j;

  // Scan farthest-first so the nearest requester after 'last' wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    j       = 0;
    for (int k = NCH; k >= 1; k--) begin
      j = (int'(last) + k) % NCH;
      if (req[j]) begin
        gnt_any = 1'b1;
        gnt_idx = CW'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arb.sv
// Round-robin burst scheduler draining NCH FIFO read ports into one registered stream.
module fifo_rd_arb
  import fifo_arb_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int DSIZE = 8,
  parameter int BURST = 4
) (
  input  logic                 rclk,
  input  logic                 rrst,
  fifo_rd_arb_if.master        bus
);

  localparam int CW   = clog2(NCH);
  localparam int CNTW = clog2(BURST + 1);

  arb_state_e      state;
  logic [CW-1:0]   sel, last, gnt_idx, pop_ch;
  logic [CNTW-1:0] cnt;
  logic [NCH-1:0]  elig;
  logic            slot_free, gnt_any, pop_idle, pop_burst, pop;

  assign elig      = bus.ch_en & ~bus.rempty;
  assign slot_free = ~bus.out_valid | bus.out_ready;

  rr_pick #(.NCH(NCH), .CW(CW)) u_pick (
    .req     (elig),
    .last    (last),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign pop_idle  = (state == S_IDLE)  & slot_free & gnt_any;
  assign pop_burst = (state == S_BURST) & slot_free & elig[sel];
  assign pop_ch    = (state == S_IDLE) ? gnt_idx : sel;
  assign pop       = (pop_idle | pop_burst) & ~rrst;
  assign bus.busy  = (state == S_BURST);

  always_comb begin
    bus.rinc = '0;
    if (pop) bus.rinc[pop_ch] = 1'b1;
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state         <= S_IDLE;
      sel           <= '0;
      last          <= CW'(NCH - 1);
      cnt           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
    end else begin
      if (pop) begin
        bus.out_data  <= bus.rdata[int'(pop_ch)*DSIZE +: DSIZE];
        bus.out_ch    <= pop_ch;
        bus.out_valid <= 1'b1;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (pop_idle) begin
            sel <= gnt_idx;
            if (BURST == 1) begin
              last <= gnt_idx;
            end else begin
              state <= S_BURST;
              cnt   <= CNTW'(1);
            end
          end
        end
        S_BURST: begin
          // Losing eligibility ends the burst; a full slot merely stalls it.
          if (!elig[sel]) begin
            state <= S_IDLE;
            last  <= sel;
          end else if (slot_free) begin
            cnt <= cnt + CNTW'(1);
            if (cnt + CNTW'(1) == CNTW'(BURST)) begin
              state <= S_IDLE;
              last  <= sel;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_arb.sv
// Directed bench: models a 4-FIFO bank, checks grant order, bubbles, stalls and reset.
module tb_fifo_rd_arb;

  localparam int NCH = 4, DSIZE = 8, BURST = 4;

  logic rclk, rrst;
  fifo_rd_arb_if #(.NCH(NCH), .DSIZE(DSIZE)) bus ();

  fifo_rd_arb #(.NCH(NCH), .DSIZE(DSIZE), .BURST(BURST)) dut (
    .rclk (rclk),
    .rrst (rrst),
    .bus  (bus)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // FIFO bank model: word = {channel, read index}
  int             lvl   [NCH];
  logic [5:0]     ptr   [NCH];
  int             ld_n  [NCH];
  logic [NCH-1:0] ld;
  logic           underflow;

  initial underflow = 1'b0;

  always @(posedge rclk) begin
    for (int i = 0; i < NCH; i++) begin
      if (ld[i]) begin
        lvl[i] <= ld_n[i];
        ptr[i] <= '0;
      end else if (bus.rinc[i]) begin
        if (lvl[i] == 0) underflow <= 1'b1;
        lvl[i] <= lvl[i] - 1;
        ptr[i] <= ptr[i] + 6'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      bus.rempty[i]         = (lvl[i] == 0);
      bus.rdata[i*8 +: 8]   = {2'(i), ptr[i]};
    end
  end

  int npass, ntot;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else npass++;
  endtask

  function automatic logic [7:0] wd(input int ch, input int p);
    return 8'((ch << 6) | p);
  endfunction

  task automatic expect_word(input int ch, input int p);
    @(negedge rclk);
    chk($sformatf("vld ch%0d w%0d", ch, p), 32'(bus.out_valid), 32'd1);
    chk($sformatf("och ch%0d w%0d", ch, p), 32'(bus.out_ch), 32'(ch));
    chk($sformatf("dat ch%0d w%0d", ch, p), 32'(bus.out_data), 32'(wd(ch, p)));
  endtask

  task automatic expect_bubble(input string tag);
    @(negedge rclk);
    chk(tag, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic do_reset(input int n0, input int n1, input int n2, input int n3);
    @(negedge rclk);
    rrst = 1'b1;
    ld_n[0] = n0; ld_n[1] = n1; ld_n[2] = n2; ld_n[3] = n3;
    ld = '1;
    #1 chk("rst_rinc", 32'(bus.rinc), 32'd0);
    @(negedge rclk);
    ld = '0;
    chk("rst_vld", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rrst = 1'b0;
  endtask

  initial begin
    npass = 0; ntot = 0;
    for (int i = 0; i < NCH; i++) begin lvl[i] = 0; ptr[i] = '0; ld_n[i] = 8; end
    rrst = 1'b1; ld = '1; bus.ch_en = 4'hF; bus.out_ready = 1'b1;

    // Reset held two cycles with every FIFO non-empty.
    @(negedge rclk);
    ld = '0;
    chk("r0_rinc", 32'(bus.rinc), 32'd0);
    chk("r0_vld", 32'(bus.out_valid), 32'd0);
    chk("r0_data", 32'(bus.out_data), 32'd0);
    chk("r0_och", 32'(bus.out_ch), 32'd0);
    chk("r0_busy", 32'(bus.busy), 32'd0);
    @(negedge rclk);
    chk("r1_rinc", 32'(bus.rinc), 32'd0);
    chk("r1_vld", 32'(bus.out_valid), 32'd0);
    rrst = 1'b0;
    #1 chk("first_rinc", 32'(bus.rinc), 32'h1);

    // Fair drain: 32 words back to back.
    for (int k = 0; k < 32; k++) expect_word((k / 4) % 4, (k / 16) * 4 + k % 4);
    expect_bubble("drain_end");
    for (int i = 0; i < NCH; i++) chk($sformatf("drain_lvl%0d", i), 32'(lvl[i]), 32'd0);

    // Early empty on ch1: two words, one bubble, then ch2.
    do_reset(8, 2, 8, 8);
    for (int p = 0; p < 4; p++) expect_word(0, p);
    expect_word(1, 0);
    expect_word(1, 1);
    expect_bubble("early_bubble");
    for (int p = 0; p < 4; p++) expect_word(2, p);
    expect_word(3, 0);

    // Backpressure mid-burst.
    do_reset(8, 8, 8, 8);
    expect_word(0, 0);
    expect_word(0, 1);
    bus.out_ready = 1'b0;
    #1 chk("bp_rinc0", 32'(bus.rinc), 32'd0);
    repeat (5) begin
      @(negedge rclk);
      chk("bp_vld", 32'(bus.out_valid), 32'd1);
      chk("bp_och", 32'(bus.out_ch), 32'd0);
      chk("bp_data", 32'(bus.out_data), 32'(wd(0, 1)));
      chk("bp_rinc", 32'(bus.rinc), 32'd0);
      chk("bp_busy", 32'(bus.busy), 32'd1);
    end
    bus.out_ready = 1'b1;
    expect_word(0, 2);
    expect_word(0, 3);
    expect_word(1, 0);

    // Channel mask 1011: ch2 never served.
    bus.ch_en = 4'b1011;
    do_reset(8, 8, 8, 8);
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < 4; p++) expect_word(0, r * 4 + p);
      for (int p = 0; p < 4; p++) expect_word(1, r * 4 + p);
      for (int p = 0; p < 4; p++) expect_word(3, r * 4 + p);
    end
    expect_bubble("mask_end");
    chk("mask_lvl2", 32'(lvl[2]), 32'd8);
    bus.ch_en = 4'hF;

    // Reset during the ch1 burst.
    do_reset(8, 8, 8, 8);
    for (int p = 0; p < 4; p++) expect_word(0, p);
    expect_word(1, 0);
    expect_word(1, 1);
    rrst = 1'b1;
    #1 chk("mrst_rinc", 32'(bus.rinc), 32'd0);
    @(negedge rclk);
    chk("mrst_vld", 32'(bus.out_valid), 32'd0);
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    rrst = 1'b0;
    #1 chk("mrst_first", 32'(bus.rinc), 32'h1);
    expect_word(0, 4);
    expect_word(0, 5);

    chk("no_underflow", 32'(underflow), 32'd0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
